// File: rtl/cache_miss_arbiter.sv
// Round-robin miss arbiter sharing one memory read port between NUM_REQ caches.
// Optional per-requester grant/wait counters when ARB_PERF_CNT_EN is defined.
module cache_miss_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DWIDTH     = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DWIDTH-1:0]             req_data,
   output logic [NUM_REQ-1:0]            req_data_valid,
   output logic                          mem_addr_valid,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic                          mem_addr_ready,
   input  logic [DWIDTH-1:0]             mem_data
`ifdef ARB_PERF_CNT_EN
   ,
   input  logic                          perf_clear,
   output logic [NUM_REQ*32-1:0]         perf_grant_cnt,
   output logic [NUM_REQ*32-1:0]         perf_wait_cnt
`endif
);

   localparam int PW = $clog2(NUM_REQ);
   localparam logic [PW-1:0] LAST_RST = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_RESP
   } state_t;

   state_t          state, state_d;
   logic [PW-1:0]   grant, grant_d;
   logic [PW-1:0]   last_grant, last_grant_d;
   logic [NUM_REQ-1:0] grant_oh;
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;

   // First valid requester after `last`, wrapping; `last` itself scanned last.
   function automatic logic [PW-1:0] sel(
      input logic [NUM_REQ-1:0] v,
      input logic [PW-1:0]      last
   );
      logic [PW-1:0] s;
      logic [PW-1:0] cand;
      s = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = PW'((int'(last) + k) % NUM_REQ);
         if (v[cand]) s = cand;
      end
      return s;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         grant      <= '0;
         last_grant <= LAST_RST;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
      end
   end

   always_comb begin
      state_d        = state;
      grant_d        = grant;
      last_grant_d   = last_grant;
      req_ready      = '0;
      req_data       = '0;
      req_data_valid = '0;
      mem_addr_valid = 1'b0;
      mem_addr       = '0;
      unique case (state)
         S_IDLE: begin
            if (|req_valid) begin
               grant_d = sel(req_valid, last_grant);
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            mem_addr       = addr_arr[grant];
            mem_addr_valid = req_valid[grant] | mem_addr_ready;
            if (mem_addr_ready) begin
               req_ready = grant_oh;
               state_d   = S_RESP;
            end else if (!req_valid[grant]) begin
               state_d = S_IDLE;
            end
         end
         S_RESP: begin
            req_data       = mem_data;
            req_data_valid = grant_oh;
            last_grant_d   = grant;
            // Back-to-back grant: the just-served requester ranks last.
            if (|req_valid) begin
               grant_d = sel(req_valid, grant);
               state_d = S_GRANT;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] grant_cnt [NUM_REQ];
   logic [31:0] wait_cnt  [NUM_REQ];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i] <= '0;
            wait_cnt[i]  <= '0;
         end
      end else if (perf_clear) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i] <= '0;
            wait_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i])
               grant_cnt[i] <= grant_cnt[i] + 32'd1;
            if (req_valid[i] && !req_ready[i])
               wait_cnt[i] <= wait_cnt[i] + 32'd1;
         end
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
      assign perf_grant_cnt[i*32 +: 32] = grant_cnt[i];
      assign perf_wait_cnt[i*32 +: 32]  = wait_cnt[i];
   end
`endif

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Scoreboard bench for cache_miss_arbiter: directed vectors, negedge monitor.
// Covers ARB_PERF_CNT_EN counters when that macro is defined.
module tb_cache_miss_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   req_data;
   logic [N-1:0]    req_data_valid;
   logic            mem_addr_valid;
   logic [AW-1:0]   mem_addr;
   logic            mem_addr_ready;
   logic [DW-1:0]   mem_data;
`ifdef ARB_PERF_CNT_EN
   logic            perf_clear;
   logic [N*32-1:0] perf_grant_cnt;
   logic [N*32-1:0] perf_wait_cnt;
`endif

   cache_miss_arbiter #(
      .NUM_REQ   (N),
      .ADDR_WIDTH(AW),
      .DWIDTH    (DW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .req_data      (req_data),
      .req_data_valid(req_data_valid),
      .mem_addr_valid(mem_addr_valid),
      .mem_addr      (mem_addr),
      .mem_addr_ready(mem_addr_ready),
      .mem_data      (mem_data)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_clear    (perf_clear),
      .perf_grant_cnt(perf_grant_cnt),
      .perf_wait_cnt (perf_wait_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [N-1:0]  oh;
      logic [15:0]   val;
   } exp_t;

   exp_t acc_q[$];
   exp_t rsp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   logic         chk_en   = 1'b0;
   logic         chk_mav  = 1'b0;
   logic [15:0]  chk_addr = '0;
   logic [N-1:0] chk_rr   = '0;
   logic [N-1:0] chk_dv   = '0;
   logic [15:0]  chk_data = '0;
   logic         end_chk  = 1'b0;
   logic         chk_perf = 1'b0;
   logic [31:0]  exp_g0   = '0;
   logic [31:0]  exp_w0   = '0;

   logic         acc      = 1'b0;
   logic [15:0]  acc_addr = '0;
   logic [N-1:0] rdy_seen = '0;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      acc      <= mem_addr_valid & mem_addr_ready;
      acc_addr <= mem_addr;
      rdy_seen <= req_ready;
      if (req_ready != '0) begin
         if (acc_q.size() == 0) begin
            cmp("accept_unexpected", 32'(req_ready), 32'd0);
         end else begin
            e = acc_q.pop_front();
            cmp("accept_onehot", 32'(req_ready), 32'(e.oh));
            cmp("accept_addr", 32'(mem_addr), 32'(e.val));
         end
      end
      if (req_data_valid != '0) begin
         if (rsp_q.size() == 0) begin
            cmp("resp_unexpected", 32'(req_data_valid), 32'd0);
         end else begin
            e = rsp_q.pop_front();
            cmp("resp_onehot", 32'(req_data_valid), 32'(e.oh));
            cmp("resp_data", 32'(req_data), 32'(e.val));
         end
      end
      if (chk_en) begin
         cmp("mem_addr_valid", 32'(mem_addr_valid), 32'(chk_mav));
         cmp("mem_addr", 32'(mem_addr), 32'(chk_addr));
         cmp("req_ready", 32'(req_ready), 32'(chk_rr));
         cmp("req_data_valid", 32'(req_data_valid), 32'(chk_dv));
         cmp("req_data", 32'(req_data), 32'(chk_data));
      end
      if (end_chk) begin
         cmp("accepts_missing", 32'(acc_q.size()), 32'd0);
         cmp("responses_missing", 32'(rsp_q.size()), 32'd0);
      end
`ifdef ARB_PERF_CNT_EN
      if (chk_perf) begin
         for (int i = 0; i < N; i++) begin
            cmp($sformatf("perf_grant_cnt%0d", i), perf_grant_cnt[i*32 +: 32],
                (i == 0) ? exp_g0 : 32'd0);
            cmp($sformatf("perf_wait_cnt%0d", i), perf_wait_cnt[i*32 +: 32],
                (i == 0) ? exp_w0 : 32'd0);
         end
      end
`endif
   end

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      case (a)
         16'h1000: return 16'h1111;
         16'h2000: return 16'h2222;
         16'h0123: return 16'hBEEF;
         16'h4000: return 16'h4444;
         default:  return ~a;
      endcase
   endfunction

   // Memory answers the cycle after acceptance; requesters drop valid once accepted.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_data  = acc ? mem_fn(acc_addr) : 16'hDEAD;
      req_valid = req_valid & ~rdy_seen;
      chk_en    = 1'b0;
      chk_perf  = 1'b0;
   endtask

   task automatic expect_c(input logic mav, input logic [15:0] addr,
                           input logic [N-1:0] rr, input logic [N-1:0] dv,
                           input logic [15:0] data);
      chk_en   = 1'b1;
      chk_mav  = mav;
      chk_addr = addr;
      chk_rr   = rr;
      chk_dv   = dv;
      chk_data = data;
   endtask

   task automatic zeros();
      expect_c(1'b0, 16'h0, 4'b0, 4'b0, 16'h0);
   endtask

   task automatic push(input logic [N-1:0] oh, input logic [15:0] a,
                       input logic [15:0] d);
      acc_q.push_back('{oh: oh, val: a});
      rsp_q.push_back('{oh: oh, val: d});
   endtask

   task automatic do_reset();
      tick(); reset = 1'b0; zeros();
      tick(); zeros();
      tick(); reset = 1'b1; zeros();
   endtask

   initial begin
      reset          = 1'b0;
      req_valid      = '0;
      mem_addr_ready = 1'b0;
      mem_data       = 16'hDEAD;
      req_addr       = {16'h4000, 16'h0123, 16'h2000, 16'h1000};
`ifdef ARB_PERF_CNT_EN
      perf_clear     = 1'b0;
`endif
      tick(); zeros();
      tick(); zeros();
      tick(); reset = 1'b1; zeros();

      // single request from requester 2
      tick(); req_valid = 4'b0100; push(4'b0100, 16'h0123, 16'hBEEF); zeros();
      tick(); mem_addr_ready = 1'b1; expect_c(1, 16'h0123, 4'b0100, 4'b0, 16'h0);
      tick(); mem_addr_ready = 1'b0; expect_c(0, 16'h0, 4'b0, 4'b0100, 16'hBEEF);
      tick(); zeros();
      do_reset();

      // round-robin, memory always ready (ignored while idle)
      tick(); req_valid = 4'b1111; mem_addr_ready = 1'b1; zeros();
      push(4'b0001, 16'h1000, 16'h1111);
      push(4'b0010, 16'h2000, 16'h2222);
      push(4'b0100, 16'h0123, 16'hBEEF);
      push(4'b1000, 16'h4000, 16'h4444);
      tick(); expect_c(1, 16'h1000, 4'b0001, 4'b0, 16'h0);
      tick(); expect_c(0, 16'h0, 4'b0, 4'b0001, 16'h1111);
      tick(); expect_c(1, 16'h2000, 4'b0010, 4'b0, 16'h0);
      tick(); expect_c(0, 16'h0, 4'b0, 4'b0010, 16'h2222);
      tick(); expect_c(1, 16'h0123, 4'b0100, 4'b0, 16'h0);
      tick(); expect_c(0, 16'h0, 4'b0, 4'b0100, 16'hBEEF);
      tick(); expect_c(1, 16'h4000, 4'b1000, 4'b0, 16'h0);
      tick(); expect_c(0, 16'h0, 4'b0, 4'b1000, 16'h4444);
      tick(); zeros();

      // memory stall with requester 3 arriving mid-stall
      tick(); mem_addr_ready = 1'b0; req_valid = 4'b0001; zeros();
      push(4'b0001, 16'h1000, 16'h1111);
      push(4'b1000, 16'h4000, 16'h4444);
      tick(); expect_c(1, 16'h1000, 4'b0, 4'b0, 16'h0);
      tick(); req_valid = 4'b1001; expect_c(1, 16'h1000, 4'b0, 4'b0, 16'h0);
      for (int s = 0; s < 3; s++) begin
         tick(); expect_c(1, 16'h1000, 4'b0, 4'b0, 16'h0);
      end
      tick(); mem_addr_ready = 1'b1; expect_c(1, 16'h1000, 4'b0001, 4'b0, 16'h0);
      tick(); mem_addr_ready = 1'b0; expect_c(0, 16'h0, 4'b0, 4'b0001, 16'h1111);
      tick(); mem_addr_ready = 1'b1; expect_c(1, 16'h4000, 4'b1000, 4'b0, 16'h0);
      tick(); mem_addr_ready = 1'b0; expect_c(0, 16'h0, 4'b0, 4'b1000, 16'h4444);
      tick(); zeros();

      // abandon by requester 1; pointer must stay at 3
      tick(); req_valid = 4'b0010; zeros();
      tick(); expect_c(1, 16'h2000, 4'b0, 4'b0, 16'h0);
      tick(); req_valid = 4'b0000; expect_c(0, 16'h2000, 4'b0, 4'b0, 16'h0);
      tick(); req_valid = 4'b1111; push(4'b0001, 16'h1000, 16'h0); zeros();
      void'(rsp_q.pop_back());
      tick(); mem_addr_ready = 1'b1; expect_c(1, 16'h1000, 4'b0001, 4'b0, 16'h0);

      // asynchronous reset during the response cycle
      tick(); reset = 1'b0; mem_addr_ready = 1'b0; zeros();
      tick(); zeros();
      tick(); reset = 1'b1; push(4'b0010, 16'h2000, 16'h2222); zeros();
      tick(); mem_addr_ready = 1'b1; expect_c(1, 16'h2000, 4'b0010, 4'b0, 16'h0);
      tick(); mem_addr_ready = 1'b0; req_valid = '0;
      expect_c(0, 16'h0, 4'b0, 4'b0010, 16'h2222);
      tick(); zeros();

`ifdef ARB_PERF_CNT_EN
      tick(); perf_clear = 1'b1; zeros();
      tick(); perf_clear = 1'b0; zeros();
      exp_g0 = 32'd0; exp_w0 = 32'd0; chk_perf = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick(); req_valid = 4'b0001; push(4'b0001, 16'h1000, 16'h1111); zeros();
         tick(); expect_c(1, 16'h1000, 4'b0, 4'b0, 16'h0);
         tick(); expect_c(1, 16'h1000, 4'b0, 4'b0, 16'h0);
         tick(); mem_addr_ready = 1'b1; expect_c(1, 16'h1000, 4'b0001, 4'b0, 16'h0);
         tick(); mem_addr_ready = 1'b0; expect_c(0, 16'h0, 4'b0, 4'b0001, 16'h1111);
      end
      tick(); zeros(); exp_g0 = 32'd3; exp_w0 = 32'd9; chk_perf = 1'b1;
      perf_clear = 1'b1;
      tick(); perf_clear = 1'b0; zeros();
      exp_g0 = 32'd0; exp_w0 = 32'd0; chk_perf = 1'b1;
`endif

      tick(); end_chk = 1'b1;
      tick(); end_chk = 1'b0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_miss_arbiter.md
Name: cache_miss_arbiter

Overview:
- Shares one memory read port between NUM_REQ directly-mapped caches, using each cache's miss-side valid/ready/data protocol.
- Round-robin grant: one outstanding memory request at a time.
- Returns the memory data one cycle after acceptance, tagged to the granted requester.
- Sits between the cache array and the instruction/data memory of the regex engine core.

Parameters:
NUM_REQ, 4, number of requesting caches (>=2)
ADDR_WIDTH, 16, address width
DWIDTH, 16, data word width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  NUM_REQ  per-requester miss request valid
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH+:ADDR_WIDTH]
req_ready  out  NUM_REQ  one-hot; request i accepted by memory this cycle
req_data  out  DWIDTH  returned word, broadcast to all requesters
req_data_valid  out  NUM_REQ  one-hot; req_data belongs to requester i this cycle
mem_addr_valid  out  1  memory request valid
mem_addr  out  ADDR_WIDTH  memory request address
mem_addr_ready  in  1  memory accepted; mem_data valid the following cycle
mem_data  in  DWIDTH  memory read data

Behaviour:
- Reset (reset=0, asynchronous), all outputs and state as listed:
  - state=S_IDLE, grant=0, last_grant=NUM_REQ-1.
  - req_ready=0, req_data_valid=0, mem_addr_valid=0, mem_addr=0, req_data=0.
  - Any in-flight response is discarded. Deassertion is sampled on the next rising edge.
- States: S_IDLE, S_GRANT, S_RESP.
- Selection function sel:
  - First i with req_valid[i]=1, scanning (last_grant+1) mod NUM_REQ upward with wrap.
  - The last-served requester has the lowest priority.
- S_IDLE:
  - If any req_valid: grant<=sel, go to S_GRANT.
  - Otherwise stay. Outputs idle.
- S_GRANT:
  - mem_addr_valid=1; mem_addr=req_addr[grant] (combinational passthrough). The requester holds its address stable.
  - If mem_addr_ready=1: req_ready[grant]=1 in the same cycle; go to S_RESP.
  - If req_valid[grant]=0 and mem_addr_ready=0: request abandoned. mem_addr_valid=0 that cycle, go to S_IDLE, last_grant unchanged.
- S_RESP:
  - req_data=mem_data; req_data_valid[grant]=1; last_grant<=grant.
  - If any req_valid: grant<=sel, computed with grant as the new last_grant, and go to S_GRANT. This is a back-to-back grant with no idle bubble.
  - Otherwise go to S_IDLE.
- Latency:
  - req_valid rises in cycle t → mem_addr_valid in t+1.
  - With mem_addr_ready in t+1 → req_data_valid in t+2.
  - Sustained throughput is one request per 2 cycles.
- Outside S_RESP: req_data=0, req_data_valid=0.
- At most one bit of req_ready and of req_data_valid is set in any cycle.
- New req_valid arrivals during S_GRANT do not change grant; no preemption.
- mem_addr_ready while not in S_GRANT is ignored.
- Single requester active: it is re-granted every 2 cycles.
- Index arithmetic is modulo NUM_REQ. The grant pointer width is $clog2(NUM_REQ).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Extra output perf_grant_cnt, NUM_REQ*32 bits, packed like req_addr. Counter i increments on each cycle req_ready[i]=1.
  - Extra output perf_wait_cnt, NUM_REQ*32 bits. Counter i increments each cycle req_valid[i]=1 and req_ready[i]=0.
  - Both counters wrap at 2^32-1 → 0 and reset to 0.
  - Extra input perf_clear, 1 bit, synchronously zeroes all counters; clear has priority over increment.
- When undefined: the ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Single request:
  - Stimulus: NUM_REQ=4, after reset req_valid=4'b0100, req_addr[2]=16'h0123, mem_addr_ready=1 in first GRANT cycle, mem_data=16'hBEEF.
  - Response: mem_addr=16'h0123 in t+1, req_ready=4'b0100 in t+1, req_data_valid=4'b0100 with req_data=16'hBEEF in t+2.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held, each requester dropping its valid after its own req_ready; memory always ready.
  - Response: grant order 0,1,2,3 on consecutive 2-cycle slots with no idle cycle.
- Memory stall:
  - Stimulus: req_valid=4'b0001, mem_addr_ready=0 for 5 cycles then 1; req_valid[3] rises during the stall.
  - Response: mem_addr_valid held 6 cycles with addr[0], grant not switched, then requester 3 granted right after S_RESP.
- Abandon:
  - Stimulus: requester 1 granted, drops req_valid before any mem_addr_ready.
  - Response: mem_addr_valid=0 next cycle, state S_IDLE, no req_data_valid; next sel still starts at requester 0 (last_grant=3).
- Reset mid-operation:
  - Stimulus: assert reset=0 asynchronously during S_RESP.
  - Response: req_data_valid and mem_addr_valid drop to 0 immediately without a clock edge; after release the first grant goes to the lowest valid index.
- ARB_PERF_CNT_EN:
  - Stimulus: 3 grants to requester 0 with 2 stall cycles each, then pulse perf_clear.
  - Response: perf_grant_cnt[0]=3 and perf_wait_cnt[0]=9, i.e. 1 arbitration cycle plus 2 stall cycles per request; all counters 0 the cycle after the clear.
